ad_trig_capture: RTL and testbench
==================================

// Module: ad_trig_capture
// PURPOSE
// - Downstream of the ADC bit-order/register stage. Consumes one 12-bit sample per ad_clk on ad_ch1.
// - Captures a triggered waveform into a circular buffer, holding PRE_TRIG samples before the trigger.
// - Replays the DEPTH samples in time order over a valid/ready stream for the display/UART path.
// PARAMETERS
// - DATA_W    12    sample width
// - ADDR_W    10    buffer address width; DEPTH = 2**ADDR_W = 1024
// - PRE_TRIG  256   samples kept before the trigger; legal range 1..DEPTH-1
// PORTS
// - ad_clk      in   1       sample clock; the only clock
// - rst_n       in   1       synchronous, active-low reset
// - ad_ch1      in   DATA_W  sample, valid every cycle
// - arm         in   1       1-cycle pulse: start a capture (accepted only in IDLE)
// - abort       in   1       return to IDLE from any state
// - trig_level  in   DATA_W  unsigned threshold
// - trig_fall   in   1       0 = rising-edge trigger, 1 = falling-edge trigger
// - busy        out  1       high in PRE, WAIT, POST
// - rd_data     out  DATA_W  readout sample
// - rd_valid    out  1       rd_data valid
// - rd_ready    in   1       consumer accepts when rd_valid && rd_ready
// - rd_last     out  1       high with the final (DEPTH-th) sample
// BEHAVIOUR
// - Reset values: busy=0, rd_valid=0, rd_last=0, rd_data=0. State=IDLE, wr_ptr=0, counters=0.
// - Reset mid-operation aborts immediately. Buffer contents are don't-care.
// - States: IDLE -> PRE -> WAIT -> POST -> READ -> IDLE.
//   - IDLE: on arm, go to PRE with wr_ptr=0 and pre_cnt=0.
//   - PRE: write ad_ch1 at wr_ptr each cycle, wr_ptr++ (wraps mod DEPTH).
//     Go to WAIT after PRE_TRIG writes.
//   - WAIT: keep writing and wrapping.
//     - Trigger on the sample being written (cur) against the previous sample (prev).
//     - Rising: prev < trig_level && cur >= trig_level.
//     - Falling: prev >= trig_level && cur < trig_level.
//     - On trigger: latch trig_addr = wr_ptr, go to POST with post_cnt=1 (trigger sample counts).
//   - PRE never evaluates the trigger; a crossing during PRE is ignored.
//     The first WAIT cycle uses the last PRE sample as prev.
//   - POST: write until post_cnt reaches DEPTH-PRE_TRIG, then go to READ.
//     - rd_ptr = (trig_addr - PRE_TRIG) mod DEPTH.
//     - Total captured samples = PRE_TRIG + (DEPTH-PRE_TRIG) = DEPTH.
//   - READ: no writes.
//     - Emit DEPTH samples from rd_ptr upward, wrapping mod DEPTH.
//     - RAM read latency is 1 cycle: first rd_valid 2 cycles after entering READ.
//     - Stall: when rd_valid && !rd_ready, rd_data, rd_valid and rd_last hold stable and the read address does not advance.
//     - rd_last asserts with sample DEPTH-1. After it is accepted: rd_valid=0, go to IDLE.
// - abort: any state -> IDLE next cycle; rd_valid/rd_last deassert; busy=0.
//   abort wins over arm and trigger in the same cycle.
// - arm outside IDLE is ignored, including during READ.
// - Comparisons are unsigned, full DATA_W. Pointers wrap naturally at ADDR_W bits.
// - No trigger ever: remains in WAIT (busy=1) until abort or reset.
// STRUCTURE
// - Shared package/header: state encodings (IDLE, PRE, WAIT, POST, READ), DATA_W, ADDR_W.
// - Sub-module ad_buf_ram: simple dual-port RAM, DEPTH x DATA_W.
//   - Sync write port.
//   - Sync read port with 1-cycle latency and read-enable, so it can hold during stalls.
// - Top level holds the FSM, pointers, trigger compare and output register.
// TESTING
// - Ramp 0..4095, level=2048, rising, DEPTH=1024, PRE=256, arm after 10 cycles.
//   -> Readout is 1024 consecutive values with sample[256]=2048 and sample[255]=2047. rd_last on #1023.
// - Same ramp, trig_fall=1, level=100 with a descending ramp.
//   -> sample[256] is the first value <100 and sample[255]=100.
// - Crossing occurs 50 samples after arm (within PRE).
//   -> Ignored. Capture triggers on the next crossing, 4096 samples later.
// - rd_ready toggled 1,0,0,1 during READ.
//   -> No sample lost or duplicated; rd_data stable while stalled. Exactly 1024 handshakes.
// - abort in POST, then rst_n=0 during READ.
//   -> Both return to IDLE next cycle: busy=0, rd_valid=0. A new arm restarts a clean capture.
// - Constant input 1000, level=2048.
//   -> busy stays 1 indefinitely and rd_valid never asserts. An arm pulse during WAIT changes nothing.

Source files
------------

// File: rtl/ad_trig_capture_pkg.sv
// Shared definitions for the triggered ADC capture path: default sizes and
// the capture FSM state encoding.
package ad_trig_capture_pkg;

    localparam int DATA_W   = 12;
    localparam int ADDR_W   = 10;
    localparam int PRE_TRIG = 256;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_WAIT,
        ST_POST,
        ST_READ
    } state_e;

endpackage

// File: rtl/ad_buf_ram.sv
// Simple dual-port capture buffer: synchronous write, registered read with a
// read enable so the output word holds while the consumer stalls.
module ad_buf_ram
    import ad_trig_capture_pkg::*;
#(
    parameter int DATA_W = ad_trig_capture_pkg::DATA_W,
    parameter int ADDR_W = ad_trig_capture_pkg::ADDR_W
) (
    input  logic              ad_clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // NOTE: the array and its read register carry no reset; contents are
    // don't-care after reset and a reset term would prevent block-RAM mapping.
    always_ff @(posedge ad_clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/ad_trig_capture.sv
// Triggered waveform capture: circular pre-trigger buffering, edge trigger on
// a level crossing, then time-ordered replay over a valid/ready stream.
module ad_trig_capture
    import ad_trig_capture_pkg::*;
#(
    parameter int DATA_W   = ad_trig_capture_pkg::DATA_W,
    parameter int ADDR_W   = ad_trig_capture_pkg::ADDR_W,
    parameter int PRE_TRIG = ad_trig_capture_pkg::PRE_TRIG
) (
    input  logic              ad_clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] ad_ch1,
    input  logic              arm,
    input  logic              abort,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_fall,
    output logic              busy,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              rd_last
);

    localparam int DEPTH    = 2**ADDR_W;
    localparam int POST_LEN = DEPTH - PRE_TRIG;
    localparam logic [ADDR_W:0] PRE_LAST  = (ADDR_W+1)'(PRE_TRIG - 1);
    localparam logic [ADDR_W:0] POST_LAST = (ADDR_W+1)'(POST_LEN - 1);
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_CNT  = (ADDR_W+1)'(DEPTH - 1);

    state_e              state, state_nxt;
    logic                wr_en, trig_hit, adv, issue, rd_fire;
    logic [ADDR_W-1:0]   wr_ptr, rd_addr;
    logic [ADDR_W:0]     cnt, rd_cnt;
    logic [DATA_W-1:0]   prev, ram_q;
    logic                s1_valid, s1_last;

    assign trig_hit = trig_fall ? (prev >= trig_level && ad_ch1 <  trig_level)
                                : (prev <  trig_level && ad_ch1 >= trig_level);
    assign rd_fire  = rd_valid && rd_ready;
    // The read pipeline moves only when the output slot is empty or being taken.
    assign adv      = !rd_valid || rd_ready;
    assign issue    = (state == ST_READ) && adv && (rd_cnt != DEPTH_CNT);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge ad_clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every combinational output is given a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (arm)                 state_nxt = ST_PRE;
            ST_PRE:  if (cnt == PRE_LAST)     state_nxt = ST_WAIT;
            ST_WAIT: if (trig_hit)            state_nxt = (POST_LEN == 1) ? ST_READ : ST_POST;
            ST_POST: if (cnt == POST_LAST)    state_nxt = ST_READ;
            ST_READ: if (rd_fire && rd_last)  state_nxt = ST_IDLE;
            default:                          state_nxt = ST_IDLE;
        endcase
        if (abort) state_nxt = ST_IDLE;
    end

    always_comb begin
        busy = 1'b0;
        unique case (state)
            ST_PRE, ST_WAIT, ST_POST: busy = 1'b1;
            default:                  busy = 1'b0;
        endcase
        wr_en = busy;
    end

    always_ff @(posedge ad_clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            cnt     <= '0;
            prev    <= '0;
            rd_addr <= '0;
            rd_cnt  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
                prev   <= ad_ch1;
            end
            unique case (state)
                ST_IDLE: if (arm) begin
                    wr_ptr <= '0;
                    cnt    <= '0;
                end
                ST_PRE:  cnt <= cnt + 1'b1;
                ST_WAIT: if (trig_hit) begin
                    cnt     <= (ADDR_W+1)'(1);
                    // Replay starts PRE_TRIG slots behind the trigger sample.
                    rd_addr <= wr_ptr - ADDR_W'(PRE_TRIG);
                    rd_cnt  <= '0;
                end
                ST_POST: cnt <= cnt + 1'b1;
                ST_READ: if (issue) begin
                    rd_addr <= rd_addr + 1'b1;
                    rd_cnt  <= rd_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    ad_buf_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
        .ad_clk  (ad_clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (ad_ch1),
        .rd_en   (adv),
        .rd_addr (rd_addr),
        .rd_data (ram_q)
    );

    // Stage 1 tracks the word inside the RAM read register; stage 2 is the
    // output register. Both advance together, so a stall freezes everything.
    always_ff @(posedge ad_clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            rd_data  <= '0;
        end else if (abort) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
        end else if (adv) begin
            s1_valid <= issue;
            s1_last  <= issue && (rd_cnt == LAST_CNT);
            rd_valid <= s1_valid;
            rd_last  <= s1_last;
            if (s1_valid) rd_data <= ram_q;
        end
    end

endmodule

// File: tb/tb_ad_trig_capture.sv
// Self-checking bench for ad_trig_capture: scenario table run against a
// sample-history reference model, plus abort/reset/no-trigger sequences.
module tb_ad_trig_capture;

    localparam int DEPTH    = 1024;
    localparam int PRE      = 256;
    localparam int POST_LEN = DEPTH - PRE;

    logic        ad_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] ad_ch1 = '0;
    logic        arm = 1'b0;
    logic        abort = 1'b0;
    logic [11:0] trig_level = '0;
    logic        trig_fall = 1'b0;
    logic        rd_ready = 1'b0;
    logic        busy, rd_valid, rd_last;
    logic [11:0] rd_data;

    always #5 ad_clk = ~ad_clk;

    ad_trig_capture dut (
        .ad_clk     (ad_clk),
        .rst_n      (rst_n),
        .ad_ch1     (ad_ch1),
        .arm        (arm),
        .abort      (abort),
        .trig_level (trig_level),
        .trig_fall  (trig_fall),
        .busy       (busy),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_last    (rd_last)
    );

    typedef enum int {SRC_UP, SRC_DOWN, SRC_CONST, SRC_RAND} src_e;

    typedef struct {
        src_e src;
        int   level;
        bit   fall;
        int   arm_val;    // arm when ad_ch1 shows this value; -1 = at once
        int   rmode;      // 0 always ready, 1 pattern 1,0,0,1, 2 random
        bit   arm_mid;    // pulse arm halfway through the readout
        bit   chk_const;
        int   e255;
        int   e256;
    } scen_t;

    int          checks = 0;
    int          errors = 0;
    src_e        src = SRC_UP;
    int          src_cnt = 0;
    logic [11:0] hist[$];
    logic [11:0] expq[$];
    logic [11:0] gotq[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [11:0] gen_sample();
        case (src)
            SRC_UP:    return 12'(src_cnt % 4096);
            SRC_DOWN:  return 12'(4095 - (src_cnt % 4096));
            SRC_CONST: return 12'd1000;
            default:   return 12'($urandom_range(0, 4095));
        endcase
    endfunction

    function automatic bit crossed(input int p, input int c, input int lvl, input bit fall);
        return fall ? (p >= lvl && c < lvl) : (p < lvl && c >= lvl);
    endfunction

    // One clock: log the sample the DUT is about to take, then drive the next.
    task automatic tick();
        hist.push_back(ad_ch1);
        @(posedge ad_clk);
        #1;
        src_cnt++;
        ad_ch1 = gen_sample();
    endtask

    task automatic set_source(input src_e s);
        src     = s;
        src_cnt = 0;
        ad_ch1  = gen_sample();
    endtask

    task automatic start_capture(input scen_t s, input string tag);
        int n;
        int t;
        set_source(s.src);
        trig_level = 12'(s.level);
        trig_fall  = s.fall;
        n = 0;
        if (s.arm_val >= 0)
            while (int'(ad_ch1) != s.arm_val && n < 5000) begin n++; tick(); end
        arm = 1'b1;
        tick();
        arm = 1'b0;
        hist.delete();
        n = 0;
        while (busy === 1'b1 && n < 20000) begin n++; tick(); end
        t = -1;
        for (int i = PRE; i < hist.size(); i++)
            if (crossed(hist[i-1], hist[i], s.level, s.fall)) begin t = i; break; end
        check({tag, " trigger_seen"}, int'(t >= 0), 1);
        check({tag, " busy_cycles"}, n, t + POST_LEN);
        expq.delete();
        for (int i = 0; i < DEPTH; i++)
            expq.push_back((t >= 0 && t - PRE + i < hist.size()) ? hist[t - PRE + i] : 12'h0);
    endtask

    task automatic collect(input int rmode, input bit arm_mid, input string tag);
        int          n_hs, mism, first_bad, stall_bad, last_bad, lat;
        bit          prev_stall, done, armed;
        logic [11:0] hd;
        logic        hl;
        n_hs = 0; mism = 0; first_bad = -1; stall_bad = 0; last_bad = 0; lat = -1;
        prev_stall = 0; done = 0; armed = 0; hd = '0; hl = 1'b0;
        gotq.delete();
        for (int k = 0; k < 8000 && !done; k++) begin
            if (rd_valid === 1'b1 && lat < 0) lat = k;
            if (prev_stall && (rd_valid !== 1'b1 || rd_data !== hd || rd_last !== hl))
                stall_bad++;
            case (rmode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = (k % 4 == 0) || (k % 4 == 3);
                default: rd_ready = 1'($urandom_range(0, 1));
            endcase
            arm = 1'b0;
            if (arm_mid && !armed && n_hs >= DEPTH / 2) begin arm = 1'b1; armed = 1; end
            prev_stall = 0;
            if (rd_valid === 1'b1 && rd_ready) begin
                gotq.push_back(rd_data);
                if (n_hs < DEPTH && rd_data !== expq[n_hs]) begin
                    mism++;
                    if (first_bad < 0) first_bad = n_hs;
                end
                if (rd_last !== (n_hs == DEPTH - 1)) last_bad++;
                n_hs++;
                if (rd_last === 1'b1 || n_hs >= DEPTH) done = 1;
            end else if (rd_valid === 1'b1) begin
                prev_stall = 1;
                hd = rd_data;
                hl = rd_last;
            end
            tick();
        end
        arm = 1'b0;
        rd_ready = 1'b0;
        check({tag, " handshakes"}, n_hs, DEPTH);
        check($sformatf("%s data_mismatches(first at %0d)", tag, first_bad), mism, 0);
        check({tag, " rd_last_position"}, last_bad, 0);
        check({tag, " stall_stability"}, stall_bad, 0);
        check({tag, " first_valid_latency"}, lat, 2);
        check({tag, " rd_valid_after_last"}, int'(rd_valid), 0);
        check({tag, " busy_after_last"}, int'(busy), 0);
        tick();
        check({tag, " still_idle"}, int'(busy), 0);
    endtask

    task automatic run_capture(input scen_t s, input string tag);
        start_capture(s, tag);
        collect(s.rmode, s.arm_mid, tag);
        if (s.chk_const) begin
            check({tag, " sample255"}, gotq.size() > 256 ? int'(gotq[255]) : -1, s.e255);
            check({tag, " sample256"}, gotq.size() > 256 ? int'(gotq[256]) : -1, s.e256);
        end
    endtask

    scen_t tbl[6];

    initial begin
        scen_t s;
        int    busy_cnt, valid_cnt;

        tbl[0] = '{SRC_UP,   2048, 1'b0, 10,   0, 1'b0, 1'b1, 2047, 2048};
        tbl[1] = '{SRC_DOWN, 100,  1'b1, 4000, 0, 1'b0, 1'b1, 100,  99};
        tbl[2] = '{SRC_UP,   2048, 1'b0, 1998, 0, 1'b0, 1'b1, 2047, 2048};
        tbl[3] = '{SRC_UP,   2048, 1'b0, 10,   1, 1'b1, 1'b1, 2047, 2048};
        tbl[4] = '{SRC_RAND, 0,    1'b0, -1,   2, 1'b0, 1'b0, 0,    0};
        tbl[5] = '{SRC_RAND, 0,    1'b0, -1,   2, 1'b0, 1'b0, 0,    0};

        set_source(SRC_UP);
        repeat (3) tick();
        check("reset busy",     int'(busy),     0);
        check("reset rd_valid", int'(rd_valid), 0);
        check("reset rd_last",  int'(rd_last),  0);
        check("reset rd_data",  int'(rd_data),  0);
        rst_n = 1'b1;
        tick();

        arm = 1'b1; abort = 1'b1;
        tick();
        arm = 1'b0; abort = 1'b0;
        check("abort_beats_arm busy", int'(busy), 0);

        for (int i = 0; i < 6; i++) begin
            s = tbl[i];
            if (s.src == SRC_RAND) begin
                s.level = $urandom_range(800, 3200);
                s.fall  = 1'($urandom_range(0, 1));
            end
            run_capture(s, $sformatf("scen%0d", i));
        end

        // Abort mid-POST: the ramp trigger lands 2037 samples after arm.
        set_source(SRC_UP);
        trig_level = 12'd2048;
        trig_fall  = 1'b0;
        while (ad_ch1 != 12'd10) tick();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        repeat (2057) tick();
        check("abort_post in_post busy", int'(busy), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_post busy", int'(busy), 0);
        check("abort_post rd_valid", int'(rd_valid), 0);
        valid_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (rd_valid !== 1'b0 || busy !== 1'b0) valid_cnt++;
        end
        check("abort_post quiet", valid_cnt, 0);
        run_capture(tbl[0], "after_abort");

        // Reset asserted during READ.
        start_capture(tbl[0], "rst_read");
        rd_ready = 1'b1;
        repeat (100) tick();
        check("rst_read in_read rd_valid", int'(rd_valid), 1);
        rst_n = 1'b0;
        tick();
        check("rst_read busy",     int'(busy),     0);
        check("rst_read rd_valid", int'(rd_valid), 0);
        check("rst_read rd_last",  int'(rd_last),  0);
        check("rst_read rd_data",  int'(rd_data),  0);
        rst_n = 1'b1;
        rd_ready = 1'b0;
        tick();
        run_capture(tbl[0], "after_rst");

        // Constant input never crosses the level: stays in WAIT, arm ignored.
        set_source(SRC_CONST);
        trig_level = 12'd2048;
        trig_fall  = 1'b0;
        rd_ready   = 1'b1;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        busy_cnt = 0;
        valid_cnt = 0;
        for (int k = 0; k < 3000; k++) begin
            arm = (k == 1500);
            tick();
            if (busy === 1'b1) busy_cnt++;
            if (rd_valid !== 1'b0) valid_cnt++;
        end
        arm = 1'b0;
        check("no_trig busy_cycles", busy_cnt, 3000);
        check("no_trig rd_valid_cycles", valid_cnt, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("no_trig abort busy", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
